// File: rtl/multicycle_control.sv
// Moore FSM sequencing the shared multicycle datapath (fetch/decode/execute/memory/writeback).
// Optional retired-instruction counter enabled by defining PERF_COUNT_EN.
module multicycle_control #(
  parameter logic [5:0]  OP_RTYPE    = 6'b000000,
  parameter logic [5:0]  OP_LW       = 6'b110001,
  parameter logic [5:0]  OP_SW       = 6'b110101,
  parameter logic [5:0]  OP_BEQ      = 6'b001000,
  parameter logic [15:0] MEM_TIMEOUT = 16'd1024
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic [5:0]  opCode,
  input  logic        memReady,
  output logic        pcWrite,
  output logic        pcWriteCond,
  output logic        iorD,
  output logic        memRead,
  output logic        memWrite,
  output logic        irWrite,
  output logic        memToReg,
  output logic        regDest,
  output logic        regWrite,
  output logic        aluSrcA,
  output logic [1:0]  aluSrcB,
  output logic [1:0]  aluOp,
  output logic [1:0]  pcSource,
  output logic [3:0]  state,
  output logic        illegalOp,
  output logic        memTimeout,
  output logic [31:0] instrRetired
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_TRAP      = 4'd15
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_e      state_q, state_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;
  logic        in_wait;
  logic        wait_expired;
  logic        retire;
  ctrl_t       ctrl;

  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

  // The last allowed not-ready cycle is counter == MEM_TIMEOUT-1; a ready on that cycle still wins.
  assign wait_expired = (MEM_TIMEOUT != 16'd0) && (wait_cnt_q == (MEM_TIMEOUT - 16'd1)) && !memReady;

  assign retire = (state_q == S_MEM_WB) || (state_q == S_R_WB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEM_WRITE) && memReady);

  // Next-state logic
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d   = state_q;
    opcode_d  = opcode_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;

    case (state_q)
      S_FETCH:     if (memReady) state_d = S_DECODE;
      S_DECODE: begin
        opcode_d = opCode;
        if (opCode == OP_RTYPE)                        state_d = S_EXEC_R;
        else if ((opCode == OP_LW) || (opCode == OP_SW)) state_d = S_MEM_ADDR;
        else if (opCode == OP_BEQ)                     state_d = S_BRANCH;
        else begin
          state_d   = S_TRAP;
          illegal_d = 1'b1;
        end
      end
      S_MEM_ADDR:  state_d = (opcode_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (memReady) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (memReady) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase

    if (in_wait && wait_expired) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end

    if (state_d != state_q)          wait_cnt_d = 16'd0;
    else if (in_wait && !memReady)   wait_cnt_d = wait_cnt_q + 16'd1;
    else                             wait_cnt_d = wait_cnt_q;
  end

`ifdef PERF_COUNT_EN
  logic [31:0] retired_q;
`endif

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_FETCH;
      opcode_q   <= 6'd0;
      wait_cnt_q <= 16'd0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef PERF_COUNT_EN
      retired_q  <= 32'd0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      wait_cnt_q <= wait_cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
`ifdef PERF_COUNT_EN
      if (retire) retired_q <= retired_q + 32'd1;
`endif
    end
  end

`ifdef PERF_COUNT_EN
  assign instrRetired = retired_q;
`else
  assign instrRetired = 32'd0;
  logic unused_retire;
  assign unused_retire = retire;
`endif

  // Moore output decode; memReady only gates the FETCH loads.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = memReady;
        ctrl.pc_write  = memReady;
      end
      S_DECODE:   ctrl.alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dest  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = 2'b01;
      end
      default: ctrl = '0;
    endcase
  end

  assign pcWrite     = ctrl.pc_write;
  assign pcWriteCond = ctrl.pc_write_cond;
  assign iorD        = ctrl.ior_d;
  assign memRead     = ctrl.mem_read;
  assign memWrite    = ctrl.mem_write;
  assign irWrite     = ctrl.ir_write;
  assign memToReg    = ctrl.mem_to_reg;
  assign regDest     = ctrl.reg_dest;
  assign regWrite    = ctrl.reg_write;
  assign aluSrcA     = ctrl.alu_src_a;
  assign aluSrcB     = ctrl.alu_src_b;
  assign aluOp       = ctrl.alu_op;
  assign pcSource    = ctrl.pc_source;
  assign state       = state_q;
  assign illegalOp   = illegal_q;
  assign memTimeout  = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table plus trap/timeout/reset sequences.
module tb_multicycle_control;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic [5:0]  opCode = 6'd0;
  logic        memReady = 1'b0;
  logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic        memToReg, regDest, regWrite, aluSrcA;
  logic [1:0]  aluSrcB, aluOp, pcSource;
  logic [3:0]  state;
  logic        illegalOp, memTimeout;
  logic [31:0] instrRetired;

  multicycle_control #(.MEM_TIMEOUT(16'd8)) dut (
    .clock(clock), .resetN(resetN), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
    .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDest(regDest),
    .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .state(state), .illegalOp(illegalOp), .memTimeout(memTimeout),
    .instrRetired(instrRetired)
  );

  always #5 clock = ~clock;

  // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDest,regWrite,aluSrcA,aluSrcB,aluOp,pcSource}
  logic [15:0] ctrl_w;
  assign ctrl_w = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                   regDest, regWrite, aluSrcA, aluSrcB, aluOp, pcSource};

  localparam logic [15:0] C_FR  = 16'b1_0_0_1_0_1_0_0_0_0_01_00_00;
  localparam logic [15:0] C_FW  = 16'b0_0_0_1_0_0_0_0_0_0_01_00_00;
  localparam logic [15:0] C_DEC = 16'b0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [15:0] C_MA  = 16'b0_0_0_0_0_0_0_0_0_1_10_00_00;
  localparam logic [15:0] C_MR  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_MWB = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
  localparam logic [15:0] C_MW  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
  localparam logic [15:0] C_EXR = 16'b0_0_0_0_0_0_0_0_0_1_00_10_00;
  localparam logic [15:0] C_RWB = 16'b0_0_0_0_0_0_0_1_1_0_00_00_00;
  localparam logic [15:0] C_BR  = 16'b0_1_0_0_0_0_0_0_0_1_00_01_01;
  localparam logic [15:0] C_TRP = 16'b0;

  localparam logic [5:0] OPR = 6'b000000, OLW = 6'b110001, OSW = 6'b110101,
                         OBQ = 6'b001000, OBAD = 6'b111111;

`ifdef PERF_COUNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic [31:0] ret;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input logic [5:0] op, input logic rdy);
    opCode   = op;
    memReady = rdy;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetN   = 1'b0;
    memReady = 1'b1;
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ctrl_rdy1", {16'd0, ctrl_w}, {16'd0, C_FR});
    check("rst_flags", {30'd0, illegalOp, memTimeout}, 32'd0);
    check("rst_retired", instrRetired, 32'd0);
    memReady = 1'b0;
    #1;
    check("rst_ctrl_rdy0", {16'd0, ctrl_w}, {16'd0, C_FW});
    @(negedge clock);
    resetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           op    rdy   st    ctrl   ret
    vecs[0]  = '{OPR,  1'b1, 4'd0, C_FR,  32'd0};
    vecs[1]  = '{OPR,  1'b1, 4'd1, C_DEC, 32'd0};
    vecs[2]  = '{OBAD, 1'b0, 4'd6, C_EXR, 32'd0};
    vecs[3]  = '{OBAD, 1'b0, 4'd7, C_RWB, 32'd0};
    vecs[4]  = '{OLW,  1'b1, 4'd0, C_FR,  32'd1};
    vecs[5]  = '{OLW,  1'b1, 4'd1, C_DEC, 32'd1};
    vecs[6]  = '{OSW,  1'b1, 4'd2, C_MA,  32'd1};
    vecs[7]  = '{OSW,  1'b0, 4'd3, C_MR,  32'd1};
    vecs[8]  = '{OSW,  1'b0, 4'd3, C_MR,  32'd1};
    vecs[9]  = '{OSW,  1'b0, 4'd3, C_MR,  32'd1};
    vecs[10] = '{OSW,  1'b1, 4'd3, C_MR,  32'd1};
    vecs[11] = '{OSW,  1'b0, 4'd4, C_MWB, 32'd1};
    vecs[12] = '{OSW,  1'b1, 4'd0, C_FR,  32'd2};
    vecs[13] = '{OSW,  1'b1, 4'd1, C_DEC, 32'd2};
    vecs[14] = '{OLW,  1'b1, 4'd2, C_MA,  32'd2};
    vecs[15] = '{OLW,  1'b1, 4'd5, C_MW,  32'd2};
    vecs[16] = '{OBQ,  1'b0, 4'd0, C_FW,  32'd3};
    vecs[17] = '{OBQ,  1'b1, 4'd0, C_FR,  32'd3};
    vecs[18] = '{OBQ,  1'b0, 4'd1, C_DEC, 32'd3};
    vecs[19] = '{OBQ,  1'b1, 4'd8, C_BR,  32'd3};
    vecs[20] = '{OSW,  1'b1, 4'd0, C_FR,  32'd4};
    vecs[21] = '{OSW,  1'b1, 4'd1, C_DEC, 32'd4};
    vecs[22] = '{OSW,  1'b0, 4'd2, C_MA,  32'd4};
    vecs[23] = '{OSW,  1'b0, 4'd5, C_MW,  32'd4};
    vecs[24] = '{OSW,  1'b1, 4'd5, C_MW,  32'd4};
    vecs[25] = '{OPR,  1'b1, 4'd0, C_FR,  32'd5};

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].op, vecs[i].rdy);
      check($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
      check($sformatf("vec%0d_ctrl", i), {16'd0, ctrl_w}, {16'd0, vecs[i].ctrl});
      check($sformatf("vec%0d_retired", i), instrRetired, PERF ? vecs[i].ret : 32'd0);
      @(negedge clock);
    end

    // Illegal opcode traps and stays trapped until reset
    do_reset();
    apply(OBAD, 1'b1);
    @(negedge clock);
    apply(OBAD, 1'b1);
    check("illegal_decode_state", {28'd0, state}, 32'd1);
    @(negedge clock);
    apply(OPR, 1'b1);
    check("illegal_flag", {31'd0, illegalOp}, 32'd1);
    check("illegal_no_timeout", {31'd0, memTimeout}, 32'd0);
    check("trap_ctrl", {16'd0, ctrl_w}, {16'd0, C_TRP});
    for (int i = 0; i < 100; i++) begin
      apply(OPR, 1'($urandom_range(0, 1)));
      check($sformatf("trap_hold%0d", i), {28'd0, state, 3'd0, illegalOp}, {28'd15, 3'd0, 1'b1});
      @(negedge clock);
    end
    check("trap_retired", instrRetired, 32'd0);
    do_reset();
    apply(OPR, 1'b0);
    check("illegal_cleared", {31'd0, illegalOp}, 32'd0);
    check("after_trap_fetch", {28'd0, state}, 32'd0);

    // FETCH timeout: eighth not-ready cycle traps
    for (int i = 0; i < 8; i++) begin
      apply(OPR, 1'b0);
      check($sformatf("to_fetch_wait%0d", i), {28'd0, state}, 32'd0);
      @(negedge clock);
    end
    apply(OPR, 1'b1);
    check("to_fetch_trap", {28'd0, state}, 32'd15);
    check("to_fetch_flag", {31'd0, memTimeout}, 32'd1);
    check("to_fetch_no_illegal", {31'd0, illegalOp}, 32'd0);

    // Ready on the final allowed cycle wins
    do_reset();
    for (int i = 0; i < 7; i++) begin
      apply(OPR, 1'b0);
      @(negedge clock);
    end
    apply(OPR, 1'b1);
    check("to_last_fetch", {28'd0, state, 3'd0, irWrite}, {28'd0, 3'd0, 1'b1});
    @(negedge clock);
    apply(OPR, 1'b1);
    check("to_last_decode", {28'd0, state}, 32'd1);
    check("to_last_no_flag", {31'd0, memTimeout}, 32'd0);

    // Wait counter restarts in MEM_READ after a partial FETCH wait
    do_reset();
    for (int i = 0; i < 5; i++) begin
      apply(OLW, 1'b0);
      @(negedge clock);
    end
    apply(OLW, 1'b1); @(negedge clock);
    apply(OLW, 1'b1); @(negedge clock);
    apply(OLW, 1'b1); @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      apply(OLW, 1'b0);
      check($sformatf("to_mr_wait%0d", i), {28'd0, state, 3'd0, memRead}, {28'd3, 3'd0, 1'b1});
      @(negedge clock);
    end
    apply(OLW, 1'b0);
    check("to_mr_trap", {28'd0, state}, 32'd15);
    check("to_mr_flag", {31'd0, memTimeout}, 32'd1);

    // Asynchronous reset mid-store drops memWrite at once
    do_reset();
    apply(OSW, 1'b1); @(negedge clock);
    apply(OSW, 1'b1); @(negedge clock);
    apply(OSW, 1'b1); @(negedge clock);
    apply(OSW, 1'b0);
    check("async_pre_memwrite", {28'd0, state, 3'd0, memWrite}, {28'd5, 3'd0, 1'b1});
    #2;
    resetN = 1'b0;
    #1;
    check("async_memwrite_low", {31'd0, memWrite}, 32'd0);
    check("async_state_fetch", {28'd0, state}, 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore FSM controller that sequences the shared multicycle datapath: one memory port, one ALU, register file, IR and PC.
- Steps each instruction through fetch, decode, execute, memory and writeback, and emits every datapath enable and mux select per cycle.
- Holds in memory-access states until the memory signals ready. Traps on an illegal opcode or a memory timeout.
- Replaces single-cycle opcode decoding in the multicycle build of the CPU.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b110001, load word opcode
- OP_SW, 6'b110101, store word opcode
- OP_BEQ, 6'b001000, branch-if-equal opcode
- MEM_TIMEOUT, 16'd1024, consecutive not-ready cycles tolerated in a memory wait state; 0 disables the timeout

Ports:
- clock  in  1  system clock, rising edge
- resetN  in  1  asynchronous active-low reset
- opCode  in  6  IR[31:26] from the datapath
- memReady  in  1  memory completed the current access this cycle
- pcWrite  out  1  unconditional PC load
- pcWriteCond  out  1  PC load qualified by ALU zero
- iorD  out  1  memory address select: 0=PC, 1=ALUOut
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- irWrite  out  1  IR load
- memToReg  out  1  writeback select: 1=MDR, 0=ALUOut
- regDest  out  1  destination select: 1=rd, 0=rt
- regWrite  out  1  register file write
- aluSrcA  out  1  ALU A select: 0=PC, 1=regA
- aluSrcB  out  2  ALU B select: 00=regB, 01=4, 10=signext imm, 11=signext imm<<2
- aluOp  out  2  00=add, 01=sub, 10=funct-decoded
- pcSource  out  2  PC source: 00=ALU result, 01=ALUOut
- state  out  4  current state, debug
- illegalOp  out  1  sticky, unsupported opcode decoded
- memTimeout  out  1  sticky, memory wait exceeded MEM_TIMEOUT
- instrRetired  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clock`; reset `resetN` is asynchronous and active-low.
- Reset:
  - state=FETCH, latched opcode=0, wait counter=0, illegalOp=0, memTimeout=0, instrRetired=0.
  - Outputs take FETCH values with memReady as sampled.
- Outputs are decoded combinationally from state (plus memReady where noted); every output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, R_WB=7, BRANCH=8, TRAP=15.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, irWrite=memReady, pcWrite=memReady.
  - memReady=1 -> DECODE; otherwise stay.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=00 (computes branch target).
  - Latches opCode into an internal register; later states use only the latched value.
  - Next state: R-type -> EXEC_R; lw/sw -> MEM_ADDR; beq -> BRANCH; any other opcode -> TRAP with illegalOp set.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00. Next: MEM_READ if latched opcode is lw, else MEM_WRITE.
- MEM_READ: memRead=1, iorD=1. memReady=1 -> MEM_WB.
- MEM_WB: regWrite=1, memToReg=1, regDest=0. Next: FETCH.
- MEM_WRITE: memWrite=1, iorD=1. memReady=1 -> FETCH.
- EXEC_R: aluSrcA=1, aluSrcB=00, aluOp=10. Next: R_WB.
- R_WB: regWrite=1, regDest=1, memToReg=0. Next: FETCH.
- BRANCH: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Next: FETCH.
- TRAP: all strobes 0; stays in TRAP until reset. illegalOp and memTimeout hold their values.
- Latency with zero-wait memory: R-type 4 cycles, lw 5, sw 4, beq 3.
- Memory wait states (FETCH, MEM_READ, MEM_WRITE):
  - Strobes are held stable while waiting.
  - The wait counter clears on entry to any state and increments on each memReady=0 cycle.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT-1 with memReady still 0, next state is TRAP and memTimeout=1.
  - memReady=1 on the final allowed cycle wins over the timeout.
- memReady outside a wait state is ignored.
- resetN falling mid-instruction forces FETCH immediately. An in-flight memWrite deasserts asynchronously.

Optional Feature:
- Macro PERF_COUNT_EN.
- Defined: instrRetired increments by 1 on each transition out of MEM_WB, R_WB, BRANCH, or MEM_WRITE with memReady=1. Wraps 0xFFFFFFFF -> 0; TRAP entries do not count.
- Undefined: no counter logic; instrRetired is tied to 0.

Test Plan:
- resetN=0 then release, memReady=1, opCode=6'b000000 -> states 0,1,6,7,0; regWrite=1 and regDest=1 only in cycle 4; instrRetired=1 (with PERF_COUNT_EN).
- opCode=6'b110001, memReady held 0 for 3 cycles in MEM_READ -> memRead=1, iorD=1 stable for 4 cycles; MEM_WB asserts memToReg=1, regWrite=1.
- opCode=6'b110101, memReady=1 -> states 0,1,2,5,0; memWrite=1 exactly one cycle; regWrite never 1.
- opCode=6'b001000 -> states 0,1,8,0; pcWriteCond=1, aluOp=01, pcSource=01 in BRANCH.
- opCode=6'b111111 -> DECODE -> TRAP; illegalOp=1; state stays 15 for 100 cycles; resetN pulse clears illegalOp and returns to FETCH.
- MEM_TIMEOUT=8, memReady=0 in FETCH -> TRAP after 8 cycles with memTimeout=1; repeat with memReady=1 on cycle 8 -> DECODE, no trap.
